// File: rtl/instruction_sender.sv
// instruction_sender
//
// Host-side transmitter for the GPU byte-wide instruction bus. One 32-bit
// instruction word plus an argument count is accepted from the command
// source and serialized as the opcode byte followed by 0-3 argument bytes,
// highest argument byte first, so that the receiver's shift-insert rebuilds
// the original word. Each byte is strobed for exactly one cycle and must be
// acknowledged within ACK_TIMEOUT cycles, otherwise the transfer is aborted.
//
// Parameters:
//   ACK_TIMEOUT   cycles to wait for i_ack after a byte strobe (1-255)
//   GAP_CYCLES    idle cycles with o_we high after a transfer (1-15)
//
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_valid        command request, taken when i_valid && o_ready
//   i_instruction  [7:0] opcode, [31:8] argument bytes
//   i_nargs        number of argument bytes to send (0-3)
//   i_ack          per-byte acknowledge from the receiver
//   o_ready        high only while idle
//   o_data         byte on the bus (0 when not sending)
//   o_we           transfer frame, active low
//   o_en           byte strobe, active low
//   o_busy         inverse of o_ready
//   o_done         one-cycle pulse: every byte acknowledged
//   o_error        one-cycle pulse: acknowledge timeout, transfer aborted

module instruction_sender #(
    parameter int ACK_TIMEOUT = 15,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_instruction,
    input  logic [1:0]  i_nargs,
    input  logic        i_ack,
    output logic        o_ready,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic        o_en,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT_ACK,
        FINISH,
        ABORT,
        GAP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] instr;
    logic [1:0]  nargs;
    logic [1:0]  idx;
    logic [7:0]  ack_cnt;
    logic [3:0]  gap_cnt;

    logic        accept;
    logic        ack_timeout;
    logic        last_byte;
    logic        gap_over;
    logic [1:0]  byte_sel;
    logic [7:0]  cur_byte;

    assign accept      = i_valid && (state == IDLE);
    // ack_cnt is 0 in the first WAIT_ACK cycle, so the last allowed wait
    // cycle is the one where it holds ACK_TIMEOUT-1.
    assign ack_timeout = (ack_cnt == 8'(ACK_TIMEOUT - 1));
    assign last_byte   = (idx == nargs);
    assign gap_over    = (gap_cnt == 4'(GAP_CYCLES - 1));

    // Byte index 0 is the opcode; after that the arguments go out from the
    // highest latched argument byte down to byte 1.
    assign byte_sel = (idx == 2'd0) ? 2'd0 : (nargs - idx + 2'd1);
    assign cur_byte = instr[{byte_sel, 3'b000} +: 8];

    // State register plus the latched command and the byte/timeout/gap
    // counters. Reset clears everything so an interrupted transfer leaves
    // nothing behind.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            instr   <= '0;
            nargs   <= '0;
            idx     <= '0;
            ack_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr <= i_instruction;
                        nargs <= i_nargs;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    // An ack in the timeout cycle still counts as an ack.
                    if (i_ack) begin
                        if (!last_byte) begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                FINISH, ABORT: begin
                    gap_cnt <= '0;
                end
                GAP: begin
                    gap_cnt <= gap_over ? 4'd0 : gap_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and Moore outputs. The bus strobes only ever depend on
    // the current state, so o_en can never stay low for two cycles: SEND
    // always moves on to WAIT_ACK.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_we       = 1'b1;
        o_en       = 1'b1;
        o_done     = 1'b0;
        o_error    = 1'b0;
        o_data     = 8'd0;

        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                o_we       = 1'b0;
                state_next = SEND;
            end
            SEND: begin
                o_we       = 1'b0;
                o_en       = 1'b0;
                o_data     = cur_byte;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                o_we   = 1'b0;
                o_data = cur_byte;
                if (i_ack) begin
                    state_next = last_byte ? FINISH : SEND;
                end else if (ack_timeout) begin
                    state_next = ABORT;
                end
            end
            FINISH: begin
                o_done     = 1'b1;
                state_next = GAP;
            end
            ABORT: begin
                o_error    = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                if (gap_over) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sender.sv
// tb_instruction_sender
//
// Drives instruction_sender through a table of commands with a programmable
// acknowledge delay, plus hand-written sequences for reset mid-transfer and
// a request held across the post-transfer gap. Expected bus bytes are queued
// when a command is issued and popped by a monitor on every strobe; a
// receiver model rebuilds the word from the strobed bytes.

module tb_instruction_sender;

    localparam int ACK_TIMEOUT = 15;
    localparam int GAP_CYCLES  = 2;
    localparam int BUDGET      = 400;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        valid       = 1'b0;
    logic [31:0] instruction = '0;
    logic [1:0]  nargs       = '0;
    logic        ack         = 1'b0;

    logic        ready;
    logic [7:0]  data;
    logic        we;
    logic        en;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    instruction_sender #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_valid      (valid),
        .i_instruction(instruction),
        .i_nargs      (nargs),
        .i_ack        (ack),
        .o_ready      (ready),
        .o_data       (data),
        .o_we         (we),
        .o_en         (en),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  nargs;
        int          delay;
        bit          exp_err;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         ack_delay = 0;
    logic [7:0] rx_op     = '0;
    logic [23:0] rx_args  = '0;
    int         rx_cnt    = 0;
    vec_t       vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected bus bytes: opcode, then argument bytes nargs..1. An aborted
    // transfer in this bench never gets past its unacknowledged opcode.
    task automatic pushExpected(input logic [31:0] instr, input logic [1:0] n,
                                input bit only_opcode);
        exp_q.push_back(instr[7:0]);
        if (!only_opcode) begin
            for (int b = int'(n); b >= 1; b--) begin
                exp_q.push_back(instr[8*b +: 8]);
            end
        end
    endtask

    // Receiver-side acknowledge: ack_delay cycles after each strobe the ack
    // is high for one cycle; 0 means never acknowledge.
    initial begin : ack_responder
        int pending;
        pending = 0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    ack = 1'b1;
                end
            end
            if (!en && ack_delay > 0) begin
                pending = ack_delay;
            end
        end
    end

    // Bus monitor and receiver model.
    initial begin : monitor
        bit         prev_strobe;
        logic       prev_we;
        logic [7:0] exp_byte;
        logic [7:0] last_strobe_data;
        prev_strobe      = 1'b0;
        prev_we          = 1'b1;
        last_strobe_data = '0;
        forever begin
            @(negedge clk);
            checkOutput("busy_vs_ready", 32'(busy), 32'(!ready));
            if (ready) begin
                checkOutput("idle_data", 32'(data), 0);
            end
            if (!we && prev_we) begin
                rx_cnt  = 0;
                rx_op   = '0;
                rx_args = '0;
            end
            if (!we && en && rx_cnt > 0) begin
                checkOutput("data_held", 32'(data), 32'(last_strobe_data));
            end
            if (!en) begin
                checkOutput("en_single_cycle", 32'(prev_strobe), 0);
                checkOutput("strobe_in_frame", 32'(we), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_strobe: got %0h want none", data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("strobe_byte", 32'(data), 32'(exp_byte));
                end
                if (rx_cnt == 0) begin
                    rx_op = data;
                end else begin
                    rx_args = {rx_args[15:0], data};
                end
                rx_cnt++;
                last_strobe_data = data;
            end
            prev_strobe = !en;
            prev_we     = we;
        end
    end

    // Issues one command from the table (called at a negedge), then follows
    // it cycle by cycle until o_ready returns, checking pulse timing and the
    // rebuilt word. Cycle n counts negedges after the accepting edge, so
    // SETUP is n=1.
    task automatic applyStimulus(input vec_t v);
        int   n;
        int   done_at;
        int   err_at;
        int   ready_at;
        int   ndone;
        int   nerr;
        int   exp_end;
        logic we_at_end;
        logic [23:0] mask;

        pushExpected(v.instr, v.nargs, v.exp_err);
        ack_delay   = v.delay;
        instruction = v.instr;
        nargs       = v.nargs;
        valid       = 1'b1;
        n = 0;
        while (!ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_accept", 32'(ready), 1);
        @(posedge clk);
        @(negedge clk);
        valid     = 1'b0;
        n         = 1;
        done_at   = 0;
        err_at    = 0;
        ready_at  = 0;
        ndone     = 0;
        nerr      = 0;
        we_at_end = 1'b0;
        forever begin
            if (done) begin
                ndone++;
                done_at   = n;
                we_at_end = we;
            end
            if (error) begin
                nerr++;
                err_at    = n;
                we_at_end = we;
            end
            if (ready) begin
                ready_at = n;
                break;
            end
            if (n >= BUDGET) begin
                break;
            end
            @(negedge clk);
            n++;
        end

        if (v.exp_err) begin
            exp_end = ACK_TIMEOUT + 3;
            checkOutput("error_count", 32'(nerr), 1);
            checkOutput("done_count", 32'(ndone), 0);
            checkOutput("error_cycle", 32'(err_at), 32'(exp_end));
        end else begin
            exp_end = 1 + (int'(v.nargs) + 1) * (1 + v.delay) + 1;
            checkOutput("done_count", 32'(ndone), 1);
            checkOutput("error_count", 32'(nerr), 0);
            checkOutput("done_cycle", 32'(done_at), 32'(exp_end));
            mask = 24'((32'h1 << (8 * int'(v.nargs))) - 1);
            checkOutput("rx_word", {rx_args, rx_op}, {v.instr[31:8] & mask, v.instr[7:0]});
        end
        checkOutput("we_high_at_end", 32'(we_at_end), 1);
        checkOutput("ready_cycle", 32'(ready_at), 32'(exp_end + GAP_CYCLES + 1));
        checkOutput("bytes_left", 32'(exp_q.size()), 0);
        exp_q.delete();
        ack_delay = 0;
    endtask

    initial begin : stimulus
        int   n;
        int   strobes;
        int   done_seen;
        int   setup_at;

        vecs[0] = '{instr: 32'h0000_00A5, nargs: 2'd0, delay: 1,  exp_err: 1'b0};
        vecs[1] = '{instr: 32'h1122_3344, nargs: 2'd3, delay: 1,  exp_err: 1'b0};
        vecs[2] = '{instr: 32'hDE22_3344, nargs: 2'd2, delay: 5,  exp_err: 1'b0};
        vecs[3] = '{instr: 32'hCAFE_BE12, nargs: 2'd1, delay: 3,  exp_err: 1'b0};
        vecs[4] = '{instr: 32'h0000_0077, nargs: 2'd0, delay: ACK_TIMEOUT, exp_err: 1'b0};
        vecs[5] = '{instr: 32'h0000_005A, nargs: 2'd2, delay: 0,  exp_err: 1'b1};
        vecs[6] = '{instr: 32'h0000_0066, nargs: 2'd0, delay: ACK_TIMEOUT + 1, exp_err: 1'b1};
        vecs[7] = '{instr: 32'h8000_0001, nargs: 2'd3, delay: 2,  exp_err: 1'b0};

        // Reset, then idle: no pulses and reset values on the bus.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_pulses", {30'd0, done, error}, 0);
        end
        checkOutput("idle_bus", {we, en, ready, busy, data}, {1'b1, 1'b1, 1'b1, 1'b0, 8'h00});

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
        end

        // Reset during WAIT_ACK of argument byte k=2.
        pushExpected(32'h1122_3344, 2'd3, 1'b0);
        ack_delay   = 6;
        instruction = 32'h1122_3344;
        nargs       = 2'd3;
        valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid   = 1'b0;
        strobes = 0;
        n       = 0;
        while (strobes < 3 && n < BUDGET) begin
            if (!en) begin
                strobes++;
            end
            if (strobes < 3) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("reset_strobes_before", 32'(strobes), 3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_bus", {we, en, ready, busy, done, error, data},
                    {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        reset     = 1'b0;
        ack_delay = 0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || !we) begin
                done_seen++;
            end
        end
        checkOutput("reset_no_resume", 32'(done_seen), 0);
        checkOutput("reset_leftover", 32'(exp_q.size()), 1);
        exp_q.delete();

        // Request held through FINISH and GAP: taken only once idle again.
        pushExpected(32'h0000_00B4, 2'd0, 1'b0);
        ack_delay   = 1;
        instruction = 32'h0000_00B4;
        nargs       = 2'd0;
        valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held_first_done", 32'(n), 4);
        pushExpected(32'h0000_00C3, 2'd0, 1'b0);
        instruction = 32'h0000_00C3;
        setup_at = 0;
        for (int i = 1; i <= GAP_CYCLES + 4; i++) begin
            @(negedge clk);
            if (!we && setup_at == 0) begin
                setup_at = i;
                valid    = 1'b0;
            end
        end
        checkOutput("held_setup_cycle", 32'(setup_at), 32'(GAP_CYCLES + 2));
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held_second_done", 32'(done), 1);
        checkOutput("held_bytes_left", 32'(exp_q.size()), 0);
        valid = 1'b0;
        ack_delay = 0;
        repeat (GAP_CYCLES + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/instruction_sender.md
# instruction_sender

Host-side transmitter for the GPU byte-wide instruction bus. Accepts one 32-bit instruction word with an argument-byte count, then serializes it as an opcode byte followed by 0-3 argument bytes using the active-low write/enable strobes and the per-byte acknowledge returned by the GPU's instruction receiver. It sits between the command source (CPU/test sequencer) and the GPU instruction input. It replaces ad-hoc strobe generation with a timed, acknowledged, abortable transfer.

## Interface
Parameters:
- ACK_TIMEOUT, 15: cycles to wait for i_ack after a byte strobe before aborting (1-255).
- GAP_CYCLES, 2: cycles o_we is held high after a transfer before the next is accepted (1-15).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  command request; accepted when i_valid && o_ready.
- i_instruction  in  32  [7:0] opcode, [31:8] argument bytes.
- i_nargs  in  2  number of argument bytes to send (0-3).
- i_ack  in  1  byte acknowledge from receiver, active high.
- o_ready  out  1  high in IDLE only.
- o_data  out  8  byte on the bus.
- o_we  out  1  transfer frame, active low; high = idle/end of instruction.
- o_en  out  1  byte strobe, active low.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse: all bytes acknowledged.
- o_error  out  1  one-cycle pulse: ack timeout, transfer aborted.

## Operation
- Reset values: o_ready=1, o_data=0, o_we=1, o_en=1, o_busy=0, o_done=0, o_error=0, state IDLE, counters 0. Reset mid-transfer returns to these values on the next edge; no partial byte completes.
- On accept, latch instruction and nargs; byte index k=0 (opcode), then k=1..nargs.
- Byte order: opcode = [7:0]; then arguments from highest to lowest: for nargs=N send byte N, N-1, ..., 1 (byte n = i_instruction[8n+7:8n]). E.g. N=3: [31:24], [23:16], [15:8]; N=1: [15:8]. The receiver's shift-insert then reconstructs the original word.
- States:
  - IDLE: o_we=1, o_en=1. Accept -> SETUP.
  - SETUP (1 cycle): o_we=0, o_en=1 -> SEND.
  - SEND (exactly 1 cycle): o_we=0, o_en=0, o_data=current byte -> WAIT_ACK; timeout counter cleared.
  - WAIT_ACK: o_we=0, o_en=1, o_data held. i_ack=1 -> if k==nargs then FINISH else k++ and SEND. Counter reaches ACK_TIMEOUT with no ack -> ABORT.
  - FINISH (1 cycle): o_we=1, o_done=1 -> GAP.
  - ABORT (1 cycle): o_we=1, o_en=1, o_error=1 -> GAP.
  - GAP: o_we=1, counts GAP_CYCLES -> IDLE.
- o_en is never low for two consecutive cycles (receiver writes on every cycle both strobes are low).
- i_ack seen outside WAIT_ACK is ignored; i_ack in the same cycle the counter hits ACK_TIMEOUT counts as ack (ack wins).
- i_valid while o_ready=0 is ignored (not queued); the source must hold it.
- o_data returns to 0 in IDLE.

## Timing
- Accept at edge t: SETUP cycle t+1 (o_we falls), opcode strobe cycle t+2 (receiver captures opcode in the cycle following the o_we fall).
- With ack returned the cycle after each strobe: each byte costs 2 cycles (SEND+WAIT_ACK); total from accept to o_done = 2 + 2·(nargs+1) + 0 cycles, o_done in cycle t+3+2·(nargs+1)-1.
- nargs=0: accept t, SETUP t+1, SEND t+2, WAIT_ACK t+3 (ack), FINISH/o_done t+4, o_ready again at t+5+GAP_CYCLES.
- Abort: o_error exactly ACK_TIMEOUT+1 cycles after the unacked strobe cycle.
- o_busy = !o_ready at all times.

## Test plan
- Reset then idle 10 cycles -> o_we=1, o_en=1, o_ready=1, o_data=0, no pulses.
- i_instruction=32'h0000_00A5, nargs=0, ack 1 cycle after strobe -> single strobe with o_data=8'hA5, o_done at accept+4, o_we high at accept+4.
- i_instruction=32'h1122_3344, nargs=3, immediate acks -> strobes carry 44,11,22,33 in that order, each o_en low exactly 1 cycle, one o_done; receiver model reconstructs 32'h1122_3344.
- nargs=2, ack delayed 5 cycles per byte -> o_en stays high while waiting, o_data stable, bytes 44,22,33 for 32'hxx22_3344, no o_error.
- ACK_TIMEOUT=15, no ack after opcode -> o_error pulse 16 cycles after strobe, o_we=1, no o_done, o_ready after GAP_CYCLES.
- Reset asserted during WAIT_ACK of byte 2; i_valid held during GAP -> immediate reset values, no o_done; held request accepted only when o_ready returns.
